// File: rtl/qerv_bufreg3.sv
// qerv_bufreg3: serial buffer register holding op_b, load data and shift count for the qerv core
module qerv_bufreg3 #(
   parameter int BITS_PER_CYCLE = 4,
   parameter int LB = $clog2(BITS_PER_CYCLE)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_en,
   input  logic                      i_init,
   input  logic                      i_cnt_done,
   input  logic [1:0]                i_lsb,
   input  logic                      i_byte_valid,
   input  logic                      i_op_b_sel,
   input  logic                      i_shift_op,
   input  logic                      i_right_shift_op,
   input  logic [1:0]                i_size,
   input  logic                      i_signed,
   input  logic [BITS_PER_CYCLE-1:0] i_rs2,
   input  logic [BITS_PER_CYCLE-1:0] i_imm,
   input  logic                      i_load,
   input  logic [31:0]               i_dat,
   output logic [BITS_PER_CYCLE-1:0] o_op_b,
   output logic [BITS_PER_CYCLE-1:0] o_q,
   output logic [31:0]               o_dat,
   output logic [3:0]                o_sel,
   output logic                      o_misalign,
   output logic                      o_sh_done,
   output logic                      o_sh_done_r,
   output logic [LB-1:0]             o_sh_rem
);
   localparam int W = BITS_PER_CYCLE;
   localparam logic [5:0] WC = 6'(W);
   typedef enum logic [1:0] {IDLE, FILL, ALIGN, COUNT} state_t;
   state_t      state_q, state_d;
   logic [31:0] dat_q, dat_d, lane;
   logic [5:0]  cnt_q, cnt_d, cnt_m, ext_q, ext_d, size_bits;
   logic        misalign_q, misalign_d, sh_done_r_q, sign;
   assign o_misalign  = misalign_q;
   assign o_sh_done_r = sh_done_r_q;
   // operand select, data register update, load beat extraction and store lane replication
   always_comb begin
      o_op_b    = i_op_b_sel ? i_rs2 : i_imm;
      dat_d     = i_load ? i_dat : (i_shift_op | (i_en & i_byte_valid)) ? {o_op_b, dat_q[31:W]} : dat_q;
      ext_d     = i_load ? 6'd0 : (i_en & ~i_init) ? ext_q + WC : ext_q;
      lane      = dat_q >> {i_lsb, 3'b000};
      size_bits = i_size == 2'b00 ? 6'd8 : i_size == 2'b01 ? 6'd16 : 6'd32;
      sign      = i_size == 2'b00 ? lane[7] : i_size == 2'b01 ? lane[15] : lane[31];
      o_q       = ext_q < size_bits ? W'(lane >> ext_q) : {W{i_signed & sign}};
      o_dat     = i_size == 2'b00 ? {4{dat_q[7:0]}} : i_size == 2'b01 ? {2{dat_q[15:0]}} : dat_q;
      o_sel     = i_size == 2'b00 ? 4'b0001 << i_lsb : i_size == 2'b01 ? (i_lsb[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   end
   // phase sequencing: operand fill, optional remainder beat, count down until the counter wraps
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cnt_m      = cnt_q - WC;
      misalign_d = misalign_q;
      o_sh_done  = 1'b0;
      o_sh_rem   = '0;
      case (state_q)
         IDLE: state_d = (i_init & i_en) ? FILL : IDLE;
         FILL: begin
            cnt_d      = i_cnt_done ? {1'b0, dat_d[4:0]} : dat_d[5:0];
            misalign_d = i_cnt_done ? ((i_size == 2'b01 & i_lsb[0]) | (i_size[1] & |i_lsb)) : misalign_q;
            state_d    = !i_cnt_done ? FILL : !i_shift_op ? IDLE : (i_right_shift_op & |dat_d[LB-1:0]) ? ALIGN : COUNT;
         end
         ALIGN: begin
            o_sh_rem = cnt_q[LB-1:0];
            state_d  = COUNT;
         end
         COUNT: begin
            cnt_d     = cnt_m;
            o_sh_done = cnt_m[5];
            state_d   = sh_done_r_q ? IDLE : COUNT;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers, all cleared asynchronously so an aborted operation leaves nothing behind
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         dat_q       <= '0;
         cnt_q       <= '0;
         ext_q       <= '0;
         misalign_q  <= 1'b0;
         sh_done_r_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dat_q       <= dat_d;
         cnt_q       <= cnt_d;
         ext_q       <= ext_d;
         misalign_q  <= misalign_d;
         sh_done_r_q <= o_sh_done;
      end
   end
endmodule

// File: tb/tb_qerv_bufreg3.sv
// tb_qerv_bufreg3: directed checks of qerv_bufreg3 against a behavioural model plus literal pins
module tb_qerv_bufreg3;
   localparam int W = 4;
   logic i_clk = 0, i_rst_n = 0, i_en = 0, i_init = 0, i_cnt_done = 0, i_byte_valid = 0, i_op_b_sel = 0;
   logic i_shift_op = 0, i_right_shift_op = 0, i_signed = 0, i_load = 0;
   logic [1:0] i_lsb = 0, i_size = 0;
   logic [W-1:0] i_rs2 = 0, i_imm = 0;
   logic [31:0] i_dat = 0;
   logic [W-1:0] o_op_b, o_q;
   logic [31:0] o_dat;
   logic [3:0] o_sel;
   logic o_misalign, o_sh_done, o_sh_done_r;
   logic [1:0] o_sh_rem;
   int errors = 0, checks = 0;
   logic c_q = 0, c_dat = 0, c_sel = 0, c_mis = 0, c_done = 0, c_rem = 0;
   logic [W-1:0] e_q = 0;
   logic [31:0] e_dat = 0;
   logic [3:0] e_sel = 0;
   logic e_mis = 0, e_done = 0, e_done_r = 0;
   logic [1:0] e_rem = 0;
   int rem, fd;
   logic [31:0] got;

   qerv_bufreg3 #(.BITS_PER_CYCLE(W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_init(i_init), .i_cnt_done(i_cnt_done),
      .i_lsb(i_lsb), .i_byte_valid(i_byte_valid), .i_op_b_sel(i_op_b_sel), .i_shift_op(i_shift_op),
      .i_right_shift_op(i_right_shift_op), .i_size(i_size), .i_signed(i_signed), .i_rs2(i_rs2),
      .i_imm(i_imm), .i_load(i_load), .i_dat(i_dat), .o_op_b(o_op_b), .o_q(o_q), .o_dat(o_dat),
      .o_sel(o_sel), .o_misalign(o_misalign), .o_sh_done(o_sh_done), .o_sh_done_r(o_sh_done_r),
      .o_sh_rem(o_sh_rem)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // model: full extended load value, then sliced into beats
   function automatic logic [31:0] load_word(input logic [31:0] d, input logic [1:0] lsb, input logic [1:0] size, input logic sgn);
      int n;
      logic [31:0] m, r;
      n = size == 0 ? 8 : size == 1 ? 16 : 32;
      m = n == 32 ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
      r = (d >> (8 * lsb)) & m;
      if (sgn && r[n-1]) r = r | ~m;
      return r;
   endfunction

   function automatic logic [31:0] store_dat(input logic [31:0] v, input logic [1:0] size);
      return size == 0 ? v[7:0] * 32'h0101_0101 : size == 1 ? v[15:0] * 32'h0001_0001 : v;
   endfunction

   function automatic logic [3:0] store_sel(input logic [1:0] size, input logic [1:0] lsb);
      return size == 0 ? 4'd1 << lsb : size == 1 ? 4'd3 << (lsb & 2'd2) : 4'hF;
   endfunction

   function automatic logic mis_model(input logic [1:0] size, input logic [1:0] lsb);
      return size == 1 ? (lsb % 2 == 1) : size >= 2 ? (lsb != 0) : 1'b0;
   endfunction

   always @(negedge i_clk) begin
      check("op_b", 32'(o_op_b), 32'(i_op_b_sel ? i_rs2 : i_imm));
      if (c_q) check("q", 32'(o_q), 32'(e_q));
      if (c_dat) check("dat", o_dat, e_dat);
      if (c_sel) check("sel", 32'(o_sel), 32'(e_sel));
      if (c_mis) check("misalign", 32'(o_misalign), 32'(e_mis));
      if (c_done) begin
         check("sh_done", 32'(o_sh_done), 32'(e_done));
         check("sh_done_r", 32'(o_sh_done_r), 32'(e_done_r));
      end
      if (c_rem) check("sh_rem", 32'(o_sh_rem), 32'(e_rem));
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_flags();
      c_q = 0; c_dat = 0; c_sel = 0; c_mis = 0; c_done = 0; c_rem = 0;
   endtask

   task automatic fill(input logic [31:0] v, input logic shift, input logic bv);
      i_en = 1; i_init = 1; i_shift_op = shift; i_byte_valid = bv; i_op_b_sel = !shift;
      for (int b = 0; b < 8; b++) begin
         i_rs2 = v[W*b +: W];
         i_imm = v[W*b +: W];
         i_cnt_done = (b == 7);
         tick();
      end
      i_init = 0; i_cnt_done = 0; i_en = 0; i_byte_valid = 0;
   endtask

   task automatic store(input logic [1:0] size, input logic [1:0] lsb, input logic [31:0] v);
      clear_flags();
      i_size = size; i_lsb = lsb;
      fill(v, 0, 1);
      e_dat = store_dat(v, size); e_sel = store_sel(size, lsb); e_mis = mis_model(size, lsb);
      c_dat = 1; c_sel = 1; c_mis = 1;
      tick();
      clear_flags();
   endtask

   task automatic load(input logic [1:0] size, input logic [1:0] lsb, input logic sgn, input logic [31:0] d, output logic [31:0] res);
      logic [31:0] w;
      w = load_word(d, lsb, size, sgn);
      clear_flags();
      i_size = size; i_lsb = lsb; i_signed = sgn;
      fill(32'd0, 0, 0);
      i_load = 1; i_dat = d; e_mis = mis_model(size, lsb); c_mis = 1;
      tick();
      i_load = 0; i_en = 1; res = 0;
      for (int b = 0; b < 8; b++) begin
         e_q = w[W*b +: W]; c_q = 1;
         @(negedge i_clk);
         res[W*b +: W] = o_q;
         tick();
      end
      i_en = 0;
      clear_flags();
   endtask

   task automatic shift(input logic right, input int shamt, output int rem_seen, output int first_done);
      int k0;
      k0 = shamt / W + 1;
      clear_flags();
      rem_seen = -1; first_done = -1;
      i_right_shift_op = right;
      e_done = 0; e_done_r = 0; c_done = 1;
      fill(32'(shamt), 1, 0);
      if (right && shamt % W != 0) begin
         e_rem = 2'(shamt % W); c_rem = 1;
         @(negedge i_clk);
         rem_seen = int'(o_sh_rem);
         tick();
         c_rem = 0;
      end
      for (int k = 1; k <= k0 + 1; k++) begin
         e_done = (shamt - k * W) < 0;
         e_done_r = k > 1 && (shamt - (k - 1) * W) < 0;
         @(negedge i_clk);
         if (o_sh_done && first_done < 0) first_done = k;
         tick();
      end
      i_shift_op = 0; e_done = 0; e_done_r = 1;
      tick();
      e_done_r = 0;
      tick();
      clear_flags();
   endtask

   initial begin
      e_q = 0; e_dat = 0; e_mis = 0; e_done = 0; e_done_r = 0;
      c_q = 1; c_dat = 1; c_mis = 1; c_done = 1;
      tick(); tick();
      i_rst_n = 1;
      tick();
      clear_flags();
      store(2'd0, 2'd3, 32'h0000_00A5);
      store(2'd0, 2'd3, 32'h0000_00A5);
      @(negedge i_clk);
      check("sb_dat_pin", o_dat, 32'hA5A5_A5A5);
      check("sb_sel_pin", 32'(o_sel), 32'(4'b1000));
      tick();
      store(2'd2, 2'd1, 32'h1234_5678);
      @(negedge i_clk);
      check("sw_mis_pin", 32'(o_misalign), 32'd1);
      tick();
      store(2'd1, 2'd2, 32'h0000_BEEF);
      store(2'd1, 2'd1, 32'h0000_CAFE);
      store(2'd2, 2'd0, 32'h8765_4321);
      load(2'd0, 2'd2, 1'b1, 32'h0080_0000, got);
      check("lb_word_pin", got, 32'hFFFF_FF80);
      load(2'd1, 2'd2, 1'b0, 32'h8001_0000, got);
      check("lhu_word_pin", got, 32'h0000_8001);
      @(negedge i_clk);
      check("lhu_mis_pin", 32'(o_misalign), 32'd0);
      tick();
      load(2'd1, 2'd0, 1'b1, 32'h0000_F00F, got);
      load(2'd0, 2'd1, 1'b0, 32'h0000_FE00, got);
      load(2'd2, 2'd0, 1'b1, 32'hDEAD_BEEF, got);
      load(2'd0, 2'd3, 1'b1, 32'h7F00_0000, got);
      shift(1'b1, 7, rem, fd);
      check("srl7_rem_pin", rem, 32'd3);
      check("srl7_done_pin", fd, 32'd2);
      shift(1'b0, 0, rem, fd);
      check("sll0_done_pin", fd, 32'd1);
      shift(1'b1, 8, rem, fd);
      shift(1'b0, 7, rem, fd);
      shift(1'b1, 31, rem, fd);
      clear_flags();
      i_size = 2'd2; i_lsb = 2'd0;
      i_load = 1; i_shift_op = 1; i_en = 1; i_byte_valid = 1; i_op_b_sel = 1; i_rs2 = 4'h9; i_dat = 32'h1357_9BDF;
      tick();
      i_load = 0; i_shift_op = 0; i_en = 0; i_byte_valid = 0;
      e_dat = 32'h1357_9BDF; e_sel = 4'hF; c_dat = 1; c_sel = 1;
      tick();
      clear_flags();
      i_right_shift_op = 0; e_done = 0; e_done_r = 0; c_done = 1;
      fill(32'd20, 1, 0);
      tick(); tick();
      i_rst_n = 0;
      e_dat = 0; e_q = 0; e_mis = 0; c_dat = 1; c_q = 1; c_mis = 1;
      tick();
      i_rst_n = 1; i_shift_op = 0;
      tick(); tick();
      clear_flags();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
